// File: rtl/usensor_pkg.sv
// Shared definitions for the ultrasonic ranging responder and its controller:
// FSM state encoding and the 50 MHz timing constants both ends agree on.
package usensor_pkg;

    // Responder FSM states (3-bit, legacy-compatible constants)
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRIG_HIGH = 3'd1;
    localparam logic [2:0] ST_BURST     = 3'd2;
    localparam logic [2:0] ST_ECHO      = 3'd3;
    localparam logic [2:0] ST_HOLDOFF   = 3'd4;

    // Timing at 50 MHz, all in clock cycles
    localparam int unsigned CNT_W_50M    = 21;
    localparam int unsigned TRIG_MIN_50M = 500;      // 10 us qualifying trig
    localparam int unsigned BURST_50M    = 10000;    // 200 us 40 kHz burst
    localparam int unsigned ECHO_MAX_50M = 1900000;  // 38 ms no-object echo
    localparam int unsigned HOLDOFF_50M  = 500000;   // 10 ms dead time

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for a single asynchronous bit. Output lags the input
// by two clock edges; both stages clear on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the raw input through two flops to resolve metastability
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so both stages sample the pre-edge values.
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/usensor_responder.sv
// HC-SR04 style far-end emulator: qualifies a trig pulse from the controller,
// waits out the burst time, then answers with an echo of programmable width
// followed by a holdoff during which further trigs are ignored.
module usensor_responder
    import usensor_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_50M,
    parameter int unsigned TRIG_MIN     = TRIG_MIN_50M,
    parameter int unsigned BURST_CYCLES = BURST_50M,
    parameter int unsigned ECHO_MAX     = ECHO_MAX_50M,
    parameter int unsigned HOLDOFF      = HOLDOFF_50M
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             trig,
    input  logic [CNT_W-1:0] echo_width,
    output logic             echo,
    output logic             busy,
    output logic             short_trig,
    output logic [7:0]       pulse_count
);

    // Every timing value must fit in the counters and be at least one cycle.
    generate
        if (((ECHO_MAX >> CNT_W) != 0) || ((TRIG_MIN >> CNT_W) != 0) ||
            ((BURST_CYCLES >> CNT_W) != 0) || ((HOLDOFF >> CNT_W) != 0) ||
            (ECHO_MAX == 0) || (TRIG_MIN == 0) || (BURST_CYCLES == 0) ||
            (HOLDOFF == 0)) begin : g_bad_params
            $error("usensor_responder: timing parameters must be 1..2**CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] TRIG_MIN_C   = CNT_W'(TRIG_MIN);
    localparam logic [CNT_W-1:0] BURST_LAST_C = CNT_W'(BURST_CYCLES - 1);
    localparam logic [CNT_W-1:0] ECHO_MAX_C   = CNT_W'(ECHO_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST_C  = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);

    logic             ts;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             echo_q, echo_d;
    logic             short_q, short_d;
    logic [7:0]       count_q, count_d;
    logic [CNT_W-1:0] width_req;

    sync_2ff u_trig_sync (
        .clk   (clock),
        .rst_n (resetn),
        .d_i   (trig),
        .q_o   (ts)
    );

    // Zero means "no object" and anything beyond the timeout is clamped to it
    assign width_req = ((echo_width == '0) || (echo_width > ECHO_MAX_C)) ?
                       ECHO_MAX_C : echo_width;

    // Next-state logic: trig qualification, burst delay, echo width, holdoff
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        echo_d  = echo_q;
        short_d = 1'b0;
        count_d = count_q;

        case (state_q)
            ST_IDLE: begin
                if (ts) begin
                    state_d = ST_TRIG_HIGH;
                    cnt_d   = ONE_C;
                end
            end

            ST_TRIG_HIGH: begin
                if (ts) begin
                    // Saturate so a trig held forever never wraps the counter
                    if (cnt_q != TRIG_MIN_C) begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end else if (cnt_q == TRIG_MIN_C) begin
                    // Width is frozen here; later echo_width changes are ignored
                    state_d = ST_BURST;
                    cnt_d   = '0;
                    width_d = width_req;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end
            end

            ST_BURST: begin
                if (cnt_q == BURST_LAST_C) begin
                    state_d = ST_ECHO;
                    cnt_d   = '0;
                    echo_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end

            ST_ECHO: begin
                if (cnt_q == width_q - ONE_C) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = '0;
                    echo_d  = 1'b0;
                    count_d = count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end

            ST_HOLDOFF: begin
                if (cnt_q == HOLD_LAST_C) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                echo_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset drops echo immediately, independent of the clock
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            width_q <= '0;
            echo_q  <= 1'b0;
            short_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            echo_q  <= echo_d;
            short_q <= short_d;
            count_q <= count_d;
        end
    end

    assign echo        = echo_q;
    assign busy        = (state_q != ST_IDLE);
    assign short_trig  = short_q;
    assign pulse_count = count_q;

endmodule

// File: doc/usensor_responder.md
Name: usensor_responder

Overview:
- Emulates the far end of the ultrasonic ranging interface: watches the `trig` line driven by the sensor controller and answers with an `echo` pulse of programmable width, as an HC-SR04 module does.
- Used for on-board loopback (GPIO trig wired into it, its echo wired back to the controller) and as the bench model for controller verification.
- Echo width is set in clock cycles, so the controller's measured distance is known exactly.

Parameters:
- CNT_W, 21, width of all timing counters and of `echo_width`.
- TRIG_MIN, 500, minimum qualifying trig-high time in cycles (10 us at 50 MHz).
- BURST_CYCLES, 10000, delay from qualified trig fall to echo rise (8-cycle 40 kHz burst, 200 us).
- ECHO_MAX, 1900000, maximum echo width (38 ms no-object timeout).
- HOLDOFF, 500000, dead time after echo fall before a new trig is accepted (10 ms).

Ports:
- clock  in  1  system clock (CLOCK_50 at top level)
- resetn  in  1  asynchronous active-low reset
- trig  in  1  trigger from controller, asynchronous to clock
- echo_width  in  CNT_W  requested echo width in cycles; 0 = no object
- echo  out  1  echo pulse to controller, registered
- busy  out  1  high whenever state is not IDLE
- short_trig  out  1  one-cycle pulse when a trig shorter than TRIG_MIN is rejected
- pulse_count  out  8  completed echo pulses, wraps 255 -> 0

Behaviour:
- Reset (async, resetn=0): state IDLE, echo=0, busy=0, short_trig=0, pulse_count=0, all counters 0, synchronizer flops 0. Asserting reset mid-pulse drops echo immediately, without waiting for a clock edge.
- `trig` passes through a 2-flop synchronizer; "ts" below is the synchronizer output. Raw-to-ts latency is 2 cycles.
- States: IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF.
- IDLE, ts=1: go to TRIG_HIGH, cnt=1.
- TRIG_HIGH, ts=1: cnt++, saturating at TRIG_MIN. Trig held high indefinitely keeps the block in TRIG_HIGH; there is no timeout.
- TRIG_HIGH, ts=0, cnt>=TRIG_MIN: at this edge F, latch W, go to BURST, cnt=0.
  - W=ECHO_MAX if echo_width==0 or echo_width>ECHO_MAX; otherwise W=echo_width.
- TRIG_HIGH, ts=0, cnt<TRIG_MIN: go to IDLE, short_trig=1 for exactly one cycle.
- BURST: count BURST_CYCLES cycles; echo goes 1 at edge F+BURST_CYCLES and state becomes ECHO.
- ECHO: echo held high for exactly W cycles, so it falls at edge F+BURST_CYCLES+W.
  - At that same edge: state HOLDOFF, pulse_count++ (mod 256).
- HOLDOFF: HOLDOFF cycles, then IDLE.
  - ts is ignored in BURST, ECHO and HOLDOFF; trig activity there has no effect and does not flag short_trig.
  - A trig still high when IDLE is re-entered is treated as a new rising trig, with its cnt starting at 1.
- echo_width changes after edge F have no effect on the current pulse.
- All counters are CNT_W wide, compare with ==, never wrap in normal operation. ECHO_MAX must be < 2^CNT_W; the implementation checks parameters with an elaboration-time assertion.
- busy is combinational from registered state, so it has no added latency.

Decomposition:
- Shared package/header usensor_pkg holds:
  - state encoding (3-bit constants for IDLE..HOLDOFF);
  - 50 MHz timing constants TRIG_MIN_50M, BURST_50M, ECHO_MAX_50M and HOLDOFF_50M, shared with the controller.
- One sub-module, sync_2ff: a 1-bit, 2-stage synchronizer with async active-low reset, reused by the controller for its echo input.
- The FSM and counters stay in usensor_responder.

Test Plan:
(bench params: TRIG_MIN=4, BURST_CYCLES=8, ECHO_MAX=100, HOLDOFF=10)
- Nominal: echo_width=20, trig high 6 cycles -> echo rises exactly 8 cycles after edge F, is high exactly 20 cycles, pulse_count=1, busy falls 10 cycles after echo falls.
- Short trig: trig high 2 cycles -> no echo, single-cycle short_trig, busy high only during TRIG_HIGH, pulse_count unchanged.
- Clamp/no-object: echo_width=0, then echo_width=500 -> each echo is exactly 100 cycles wide.
- Retrigger while busy: second trig pulse during ECHO and during HOLDOFF -> ignored, echo width unaffected, no short_trig. A trig held high across the HOLDOFF->IDLE transition produces a new echo.
- Reset mid-echo: resetn low 10 cycles into ECHO -> echo=0 within the same time step (no clock edge). After release: state IDLE, pulse_count=0, next valid trig yields a normal pulse.
- Wrap: 256 back-to-back valid triggers -> pulse_count reads 0; echo_width changed during BURST does not alter that pulse.
